sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
- Run controller for one phase-sampling pass of the Ising array.
- On a start request it latches the sampler thresholds, holds the array and sampler in reset, lets the oscillators settle, then enables the sampler for a programmed window.
- It then captures the N-bit in-phase/out-of-phase vector and reports it with a done pulse.
- Sits between the host/config interface and the phase sampler plus the core reset.

Parameters:
- N, 3, number of spins; width of phase_in/result.
- RST_CYCLES, 4, cycles core_rstn/sample_rstn are held low at run start (>=1).
- DEF_MAX, 32'd255, reset value of counter_max.
- DEF_CUTOFF, 32'd128, reset value of counter_cutoff.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  cancel the current run.
- cfg_max  in  32  sampler saturation limit for the next run.
- cfg_cutoff  in  32  sampler in-phase threshold for the next run.
- settle_cycles  in  32  cycles the core runs before sampling starts.
- run_cycles  in  32  sampling window length.
- phase_in  in  N  phase vector from the sampler.
- counter_max  out  32  to sampler; registered.
- counter_cutoff  out  32  to sampler; registered.
- core_rstn  out  N/A=1  active-low reset to the oscillator array; registered.
- sample_rstn  out  1  active-low reset to the sampler; registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when result is updated.
- result  out  N  captured phase vector.
- result_valid  out  1  result holds data from a completed run.
- cfg_err  out  1  set when the latched cutoff was clamped.

Behaviour:
- Reset values:
  - State = IDLE.
  - counter_max = DEF_MAX; counter_cutoff = DEF_CUTOFF.
  - core_rstn = 0, sample_rstn = 0.
  - busy = 0, done = 0, result = 0, result_valid = 0, cfg_err = 0.
- All outputs are registered. No combinational path from input to output.
- States: IDLE, RESET, SETTLE, SAMPLE, CAPTURE, DONE. One 32-bit down-counter tmr is shared across states.
- IDLE:
  - core_rstn = 1 and sample_rstn = 0. The core free-runs and the sampler is held in reset.
  - On start & !abort at edge k:
    - Latch counter_max = cfg_max.
    - Latch counter_cutoff = min(cfg_cutoff, cfg_max); cfg_err = (cfg_cutoff > cfg_max).
    - Latch settle_cycles and run_cycles internally.
    - Clear result_valid.
    - tmr = RST_CYCLES-1; go to RESET, with busy = 1 from k+1.
- RESET:
  - core_rstn = 0, sample_rstn = 0.
  - When tmr == 0: tmr = settle-1, go to SETTLE. If settle == 0, go directly to SAMPLE with tmr = run-1.
  - Otherwise decrement tmr.
- SETTLE:
  - core_rstn = 1, sample_rstn = 0.
  - When tmr == 0: tmr = run-1, go to SAMPLE.
- SAMPLE:
  - core_rstn = 1, sample_rstn = 1. The sampler integrates for exactly max(run_cycles,1) cycles; run_cycles == 0 is treated as 1.
  - When tmr == 0, go to CAPTURE.
- CAPTURE:
  - sample_rstn stays 1. result <= phase_in (one extra cycle absorbs the sampler's register latency).
  - Go to DONE.
- DONE:
  - done = 1 and result_valid = 1 for this single cycle.
  - sample_rstn = 0, busy = 0 on the next edge; go to IDLE.
- Latency, start edge to done pulse: RST_CYCLES + settle + max(run,1) + 2 cycles.
- start while busy is ignored (not queued).
- abort in RESET, SETTLE, SAMPLE or CAPTURE:
  - Next state is IDLE; sample_rstn = 0, core_rstn = 1.
  - No done pulse. result is unchanged; result_valid stays 0 because it was cleared at start.
- abort in DONE is ignored.
- start & abort together in IDLE: abort wins; no run starts.
- counter_max and counter_cutoff change only at start acceptance, so they are stable for the whole run.
- cfg_err holds until the next accepted start.
- Async rstn mid-run forces all reset values immediately, including core_rstn = 0. On release the block enters IDLE, where core_rstn = 1.

Decomposition:
- Shared package sample_pkg:
  - State enum (6 states, 3-bit encoding).
  - Width constant CNT_W = 32.
  - Default threshold constants DEF_MAX and DEF_CUTOFF, shared with the sampler.
- No sub-module. The FSM, timer and config latches are one module; the sampler is instantiated alongside it at the top level, not inside.

Test Plan:
- Basic run, RST_CYCLES=4, settle=10, run=20, phase_in=3'b101 held:
  - done at start+36; result=3'b101; result_valid=1.
  - sample_rstn high for exactly 21 cycles (SAMPLE + CAPTURE).
- Zero lengths, settle=0, run=0:
  - SETTLE is skipped; SAMPLE lasts 1 cycle; done at start+7.
- Clamp, cfg_max=100, cfg_cutoff=200:
  - counter_cutoff=100, counter_max=100, cfg_err=1.
  - A following start with cfg_cutoff=50 clears cfg_err.
- Abort in SAMPLE on cycle 5 of 20:
  - IDLE next cycle; no done pulse; result_valid=0; result keeps its prior value.
  - sample_rstn=0 next cycle.
- start held high through a run, and start with abort together in IDLE:
  - Exactly one run per start acceptance; the start+abort edge leaves busy=0.
- rstn pulsed low during SETTLE:
  - All outputs return to reset values asynchronously; core_rstn=0 while reset is asserted.
  - counter_cutoff=128; state IDLE after release.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and constants for the Ising-array sampling run controller and its phase sampler.
package sample_pkg;

    localparam int CNT_W = 32;

    // Sampler threshold defaults, shared with the phase sampler.
    localparam logic [CNT_W-1:0] DEF_MAX    = 32'd255;
    localparam logic [CNT_W-1:0] DEF_CUTOFF = 32'd128;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_SETTLE  = 3'd2,
        S_SAMPLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Timer reload value for a window of len cycles; a zero-length window still lasts one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// Host/config side of the sample sequencer: run control, run configuration and result reporting.
interface sample_sequencer_if #(
    parameter int N = 3
);
    import sample_pkg::*;

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_max;
    logic [CNT_W-1:0] cfg_cutoff;
    logic [CNT_W-1:0] settle_cycles;
    logic [CNT_W-1:0] run_cycles;
    logic             busy;
    logic             done;
    logic [N-1:0]     result;
    logic             result_valid;
    logic             cfg_err;

    modport master (
        output start, abort, cfg_max, cfg_cutoff, settle_cycles, run_cycles,
        input  busy, done, result, result_valid, cfg_err
    );

    modport slave (
        input  start, abort, cfg_max, cfg_cutoff, settle_cycles, run_cycles,
        output busy, done, result, result_valid, cfg_err
    );

endinterface

// File: rtl/sample_sequencer.sv
// Run controller for one phase-sampling pass: reset array and sampler, settle, sample for a
// programmed window, then capture the phase vector and report it with a done pulse.
module sample_sequencer
    import sample_pkg::*;
#(
    parameter int               N          = 3,
    parameter int               RST_CYCLES = 4,
    parameter logic [CNT_W-1:0] DEF_MAX    = sample_pkg::DEF_MAX,
    parameter logic [CNT_W-1:0] DEF_CUTOFF = sample_pkg::DEF_CUTOFF
) (
    input  logic             clk,
    input  logic             rstn,
    sample_sequencer_if.slave host,
    input  logic [N-1:0]     phase_in,
    output logic [CNT_W-1:0] counter_max,
    output logic [CNT_W-1:0] counter_cutoff,
    output logic             core_rstn,
    output logic             sample_rstn
);

    localparam logic [CNT_W-1:0] RST_M1 = CNT_W'(RST_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] settle_lat;
    logic [CNT_W-1:0] run_lat;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     result_q;
    logic             result_valid_q;
    logic             cfg_err_q;

    assign host.busy         = busy_q;
    assign host.done         = done_q;
    assign host.result       = result_q;
    assign host.result_valid = result_valid_q;
    assign host.cfg_err      = cfg_err_q;

    // Every output is assigned the value it must hold in the state being entered,
    // so all of them stay registered with no input-to-output path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            tmr            <= '0;
            settle_lat     <= '0;
            run_lat        <= '0;
            counter_max    <= DEF_MAX;
            counter_cutoff <= DEF_CUTOFF;
            core_rstn      <= 1'b0;
            sample_rstn    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every register updates from pre-edge values.
            done_q <= 1'b0;
            if (host.abort && state != S_IDLE && state != S_DONE) begin
                state       <= S_IDLE;
                core_rstn   <= 1'b1;
                sample_rstn <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        core_rstn   <= 1'b1;
                        sample_rstn <= 1'b0;
                        busy_q      <= 1'b0;
                        if (host.start && !host.abort) begin
                            counter_max    <= host.cfg_max;
                            counter_cutoff <= (host.cfg_cutoff > host.cfg_max) ? host.cfg_max
                                                                               : host.cfg_cutoff;
                            cfg_err_q      <= (host.cfg_cutoff > host.cfg_max);
                            settle_lat     <= host.settle_cycles;
                            run_lat        <= host.run_cycles;
                            result_valid_q <= 1'b0;
                            tmr            <= RST_M1;
                            core_rstn      <= 1'b0;
                            busy_q         <= 1'b1;
                            state          <= S_RESET;
                        end
                    end
                    S_RESET: begin
                        if (tmr == '0) begin
                            core_rstn <= 1'b1;
                            if (settle_lat == '0) begin
                                tmr         <= len_m1(run_lat);
                                sample_rstn <= 1'b1;
                                state       <= S_SAMPLE;
                            end else begin
                                tmr   <= settle_lat - CNT_W'(1);
                                state <= S_SETTLE;
                            end
                        end else begin
                            tmr <= tmr - CNT_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (tmr == '0) begin
                            tmr         <= len_m1(run_lat);
                            sample_rstn <= 1'b1;
                            state       <= S_SAMPLE;
                        end else begin
                            tmr <= tmr - CNT_W'(1);
                        end
                    end
                    S_SAMPLE: begin
                        if (tmr == '0) begin
                            state <= S_CAPTURE;
                        end else begin
                            tmr <= tmr - CNT_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        // The extra cycle here lets the sampler's registered phase output settle.
                        result_q       <= phase_in;
                        result_valid_q <= 1'b1;
                        done_q         <= 1'b1;
                        sample_rstn    <= 1'b0;
                        state          <= S_DONE;
                    end
                    S_DONE: begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        core_rstn   <= 1'b1;
                        sample_rstn <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer: stimulus pushes expected run results, a monitor
// pops and compares them whenever a done pulse appears.
module tb_sample_sequencer;
    import sample_pkg::*;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [N-1:0]     phase_in;
    logic [CNT_W-1:0] counter_max;
    logic [CNT_W-1:0] counter_cutoff;
    logic             core_rstn;
    logic             sample_rstn;

    sample_sequencer_if #(.N(N)) host ();

    sample_sequencer #(
        .N         (N),
        .RST_CYCLES(4),
        .DEF_MAX   (32'd255),
        .DEF_CUTOFF(32'd128)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .host          (host),
        .phase_in      (phase_in),
        .counter_max   (counter_max),
        .counter_cutoff(counter_cutoff),
        .core_rstn     (core_rstn),
        .sample_rstn   (sample_rstn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [N-1:0] result;
        int           done_edge;
        int           samp_hi;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   samp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: done_edge is the clock edge that samples the pulse, counted from the start edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            samp_cnt = 0;
        end else begin
            if (!host.busy) samp_cnt = 0;
            else if (sample_rstn) samp_cnt++;
            if (host.done) begin
                check("done_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", 32'(host.result), 32'(e.result));
                    check("result_valid_at_done", 32'(host.result_valid), 32'd1);
                    check("done_latency_edge", 32'(cyc + 1), 32'(e.done_edge));
                    check("sample_rstn_high_cycles", 32'(samp_cnt), 32'(e.samp_hi));
                end
            end
        end
    end

    // Called on a negedge; the run is accepted on the following posedge.
    task automatic start_run(input logic [31:0] mx, input logic [31:0] cut,
                             input logic [31:0] st, input logic [31:0] rn,
                             input logic [N-1:0] ph, input int lat, input int samp,
                             input bit expect_done);
        exp_t e;
        host.cfg_max       = mx;
        host.cfg_cutoff    = cut;
        host.settle_cycles = st;
        host.run_cycles    = rn;
        phase_in           = ph;
        host.start         = 1'b1;
        if (expect_done) begin
            e.result    = ph;
            e.done_edge = cyc + 1 + lat;
            e.samp_hi   = samp;
            sb.push_back(e);
        end
        @(negedge clk);
        host.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (host.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(host.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        host.start = 1'b0;
        host.abort = 1'b0;
        host.cfg_max = 32'd255;
        host.cfg_cutoff = 32'd128;
        host.settle_cycles = '0;
        host.run_cycles = '0;
        phase_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_counter_max", counter_max, 32'd255);
        check("rst_counter_cutoff", counter_cutoff, 32'd128);
        check("rst_core_rstn", 32'(core_rstn), 32'd0);
        check("rst_sample_rstn", 32'(sample_rstn), 32'd0);
        check("rst_busy", 32'(host.busy), 32'd0);
        check("rst_done", 32'(host.done), 32'd0);
        check("rst_result", 32'(host.result), 32'd0);
        check("rst_result_valid", 32'(host.result_valid), 32'd0);
        check("rst_cfg_err", 32'(host.cfg_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_core_rstn", 32'(core_rstn), 32'd1);
        check("idle_sample_rstn", 32'(sample_rstn), 32'd0);

        // Basic run: 4 + 10 + 20 + 2 = 36, sampler enabled for SAMPLE + CAPTURE = 21 cycles
        start_run(32'd255, 32'd128, 32'd10, 32'd20, 3'b101, 36, 21, 1'b1);
        check("busy_after_start", 32'(host.busy), 32'd1);
        check("core_rstn_in_reset", 32'(core_rstn), 32'd0);
        wait_idle(60);

        // Zero lengths: SETTLE skipped, SAMPLE one cycle: 4 + 0 + 1 + 2 = 7
        start_run(32'd255, 32'd128, 32'd0, 32'd0, 3'b010, 7, 2, 1'b1);
        wait_idle(20);

        // Clamp: cutoff 200 over max 100
        start_run(32'd100, 32'd200, 32'd1, 32'd1, 3'b011, 8, 2, 1'b1);
        check("clamp_counter_cutoff", counter_cutoff, 32'd100);
        check("clamp_counter_max", counter_max, 32'd100);
        check("clamp_cfg_err", 32'(host.cfg_err), 32'd1);
        wait_idle(20);
        check("cfg_err_held_after_run", 32'(host.cfg_err), 32'd1);
        start_run(32'd100, 32'd50, 32'd1, 32'd1, 3'b110, 8, 2, 1'b1);
        check("unclamped_cfg_err", 32'(host.cfg_err), 32'd0);
        check("unclamped_counter_cutoff", counter_cutoff, 32'd50);
        wait_idle(20);

        // Abort on SAMPLE cycle 5 of 20 (SAMPLE entered at start edge + 6)
        start_run(32'd255, 32'd128, 32'd2, 32'd20, 3'b111, 0, 0, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_abort_sample_rstn", 32'(sample_rstn), 32'd1);
        host.abort = 1'b1;
        @(negedge clk);
        host.abort = 1'b0;
        check("abort_busy", 32'(host.busy), 32'd0);
        check("abort_sample_rstn", 32'(sample_rstn), 32'd0);
        check("abort_core_rstn", 32'(core_rstn), 32'd1);
        check("abort_result_valid", 32'(host.result_valid), 32'd0);
        check("abort_result_kept", 32'(host.result), 32'(3'b110));
        repeat (25) @(negedge clk);
        check("abort_stays_idle", 32'(host.busy), 32'd0);

        // start held through a whole run (through the DONE edge): exactly one run
        start_run(32'd255, 32'd128, 32'd0, 32'd0, 3'b001, 7, 2, 1'b1);
        host.start = 1'b1;
        repeat (7) @(negedge clk);
        host.start = 1'b0;
        @(negedge clk);
        check("held_start_single_run", 32'(host.busy), 32'd0);
        repeat (10) @(negedge clk);

        // start and abort together in IDLE: no run
        host.start = 1'b1;
        host.abort = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        host.abort = 1'b0;
        check("start_abort_busy", 32'(host.busy), 32'd0);
        check("start_abort_core_rstn", 32'(core_rstn), 32'd1);

        // Async reset during SETTLE (SETTLE entered at start edge + 4)
        start_run(32'd100, 32'd200, 32'd10, 32'd5, 3'b100, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        check("settle_core_rstn", 32'(core_rstn), 32'd1);
        check("settle_cfg_err", 32'(host.cfg_err), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_core_rstn", 32'(core_rstn), 32'd0);
        check("async_counter_cutoff", counter_cutoff, 32'd128);
        check("async_counter_max", counter_max, 32'd255);
        check("async_busy", 32'(host.busy), 32'd0);
        check("async_cfg_err", 32'(host.cfg_err), 32'd0);
        check("async_result", 32'(host.result), 32'd0);
        check("async_result_valid", 32'(host.result_valid), 32'd0);
        @(negedge clk);
        check("held_rst_core_rstn", 32'(core_rstn), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_core_rstn", 32'(core_rstn), 32'd1);
        check("post_rst_busy", 32'(host.busy), 32'd0);
        check("post_rst_counter_cutoff", counter_cutoff, 32'd128);
        repeat (20) @(negedge clk);
        check("post_rst_stays_idle", 32'(host.busy), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
